// File: rtl/tinyqv_prefetch_pkg.sv
// Shared types for the TinyQV instruction prefetcher.
// Holds the FSM state encoding and the halfword address width.
package tinyqv_prefetch_pkg;

  localparam int HW_ADDR_W = 23;

  typedef logic [HW_ADDR_W-1:0] hw_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_REDIR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

endpackage

// File: rtl/tinyqv_prefetch_fifo.sv
// Circular buffer of 16-bit instruction halfwords.
// Flush wins over push/pop; push while full is only taken with a pop.
module tinyqv_prefetch_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [15:0]   data_i,
  output logic [15:0]   data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetcher between the TinyQV decoder and the memory
// controller fetch port: restart/stall sequencing, halfword FIFO, redirects.
module tinyqv_instr_prefetch
  import tinyqv_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_jump,
  input  logic [22:0] cpu_pc,
  output logic        cpu_instr_valid,
  output logic [15:0] cpu_instr_data,
  output logic [22:0] cpu_instr_addr,
  input  logic        cpu_instr_ack,
  output logic [22:0] instr_addr,
  output logic        instr_fetch_restart,
  output logic        instr_fetch_stall,
  input  logic        instr_fetch_started,
  input  logic        instr_fetch_stopped,
  input  logic [15:0] instr_data,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e   state_q, state_d;
  hw_addr_t fetch_addr_q, fetch_addr_d;
  hw_addr_t head_addr_q, head_addr_d;

  logic [CW-1:0] count;
  logic [15:0]   head_data;
  logic          empty, full;
  logic          stream, push, pop;

  assign stream = (state_q == ST_STREAM);
  assign pop    = !empty && cpu_instr_ack && !cpu_jump;
  assign push   = stream && instr_ready && !cpu_jump && (!full || pop);

  tinyqv_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(cpu_jump),
    .data_i (instr_data),
    .data_o (head_data),
    .count_o(count),
    .empty_o(empty),
    .full_o (full)
  );

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    head_addr_d  = head_addr_q;
    if (push) fetch_addr_d = fetch_addr_q + HW_ADDR_W'(1);
    if (pop)  head_addr_d  = head_addr_q + HW_ADDR_W'(1);
    if (cpu_jump) begin
      fetch_addr_d = cpu_pc;
      head_addr_d  = cpu_pc;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_jump) state_d = ST_START;
      end
      ST_START: begin
        // An accepted fetch racing a jump targets the old address.
        if (instr_fetch_started)
          state_d = cpu_jump ? ST_FLUSH : ST_STREAM;
        else if (cpu_jump)
          state_d = ST_REDIR;
      end
      ST_REDIR: begin
        state_d = instr_fetch_started ? ST_FLUSH : ST_START;
      end
      ST_STREAM: begin
        if (instr_fetch_stopped) state_d = ST_START;
        else if (cpu_jump)       state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (instr_fetch_stopped) state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      head_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      head_addr_q  <= head_addr_d;
    end
  end

  assign cpu_instr_valid = !empty;
  assign cpu_instr_data  = empty ? 16'h0 : head_data;
  assign cpu_instr_addr  = head_addr_q;
  assign instr_addr      = fetch_addr_q;

  assign instr_fetch_restart =
    (state_q == ST_START && !instr_fetch_started) ||
    (state_q == ST_FLUSH);
  assign instr_fetch_stall =
    (state_q == ST_FLUSH) || (stream && full);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(stream && instr_ready && !cpu_jump && full && !pop)
  );

endmodule
